nn0_axil_arbiter: RTL

- Shares the single AXI4-Lite master path into the nn0 S00_AXI register slave (4 x 32-bit registers, offsets 0x0/0x4/0x8/0xC) between two internal requesters.
  - Requester 0: host command path.
  - Requester 1: config loader.
- Round-robin arbitration, one outstanding transaction at a time.
- Runs the AXI4-Lite write (AW/W concurrent) or read handshake and returns data and response to the granted requester.
- Counts error responses.

---
 rtl/nn0_axil_pkg.sv | 22 ++
 rtl/nn0_axil_arbiter_if.sv | 51 +++++
 rtl/nn0_rr_arb2.sv | 21 ++
 rtl/nn0_axil_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/nn0_axil_pkg.sv
// rtl/nn0_axil_pkg.sv - shared encodings for the nn0 AXI4-Lite arbiter
package nn0_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] REG0_OFFSET = 4'h0;
  localparam logic [3:0] REG1_OFFSET = 4'h4;
  localparam logic [3:0] REG2_OFFSET = 4'h8;
  localparam logic [3:0] REG3_OFFSET = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR_DATA,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA
  } state_e;

endpackage

// File: rtl/nn0_axil_arbiter_if.sv
// rtl/nn0_axil_arbiter_if.sv - AXI4-Lite master path into the nn0 S00_AXI slave
interface nn0_axil_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [2:0]              m_axi_awprot;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic [2:0]              m_axi_arprot;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/nn0_rr_arb2.sv
// rtl/nn0_rr_arb2.sv - two-way round-robin grant; a tie goes to the requester not granted last
module nn0_rr_arb2 (
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/nn0_axil_arbiter.sv
// rtl/nn0_axil_arbiter.sv - shares one AXI4-Lite master between host command path and config loader
module nn0_axil_arbiter
  import nn0_axil_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     req0_valid,
  input  logic                     req0_write,
  input  logic [ADDR_WIDTH-1:0]    req0_addr,
  input  logic [DATA_WIDTH-1:0]    req0_wdata,
  input  logic [DATA_WIDTH/8-1:0]  req0_wstrb,
  output logic                     req0_ready,
  output logic                     req0_done,
  output logic [DATA_WIDTH-1:0]    req0_rdata,
  output logic [1:0]               req0_resp,
  input  logic                     req1_valid,
  input  logic                     req1_write,
  input  logic [ADDR_WIDTH-1:0]    req1_addr,
  input  logic [DATA_WIDTH-1:0]    req1_wdata,
  input  logic [DATA_WIDTH/8-1:0]  req1_wstrb,
  output logic                     req1_ready,
  output logic                     req1_done,
  output logic [DATA_WIDTH-1:0]    req1_rdata,
  output logic [1:0]               req1_resp,
  nn0_axil_arbiter_if.master       m_axi,
  output logic                     busy,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  state_e                    state_q, state_d;
  logic                      last_grant_q, last_grant_d;
  logic                      id_q, id_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [1:0]                done_q, done_d;
  logic [DATA_WIDTH-1:0]     rdata_q [2];
  logic [DATA_WIDTH-1:0]     rdata_d [2];
  logic [1:0]                resp_q [2];
  logic [1:0]                resp_d [2];
  logic [ERR_CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

  logic [1:0] grant;
  logic       arb_en;
  logic       aw_hs, w_hs;
  logic       cap_valid;
  logic [1:0] cap_resp;

  // Gating with ARESETN keeps ready low while reset is held, even if a requester is pending.
  assign arb_en = (state_q == ST_IDLE) && ARESETN;

  nn0_rr_arb2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .enable     (arb_en),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign m_axi.m_axi_awaddr  = addr_q;
  assign m_axi.m_axi_awprot  = 3'b000;
  assign m_axi.m_axi_awvalid = (state_q == ST_WADDR_DATA) && !aw_done_q;
  assign m_axi.m_axi_wdata   = wdata_q;
  assign m_axi.m_axi_wstrb   = wstrb_q;
  assign m_axi.m_axi_wvalid  = (state_q == ST_WADDR_DATA) && !w_done_q;
  assign m_axi.m_axi_bready  = (state_q == ST_WRESP);
  assign m_axi.m_axi_araddr  = addr_q;
  assign m_axi.m_axi_arprot  = 3'b000;
  assign m_axi.m_axi_arvalid = (state_q == ST_RADDR);
  assign m_axi.m_axi_rready  = (state_q == ST_RDATA);

  assign aw_hs = m_axi.m_axi_awvalid && m_axi.m_axi_awready;
  assign w_hs  = m_axi.m_axi_wvalid && m_axi.m_axi_wready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    done_d       = 2'b00;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    err_cnt_d    = err_cnt_q;
    cap_valid    = 1'b0;
    cap_resp     = RESP_OKAY;

    case (state_q)
      ST_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (grant[1]) begin
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          addr_d       = req1_addr;
          wdata_d      = req1_wdata;
          wstrb_d      = req1_wstrb;
          state_d      = req1_write ? ST_WADDR_DATA : ST_RADDR;
        end else if (grant[0]) begin
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          addr_d       = req0_addr;
          wdata_d      = req0_wdata;
          wstrb_d      = req0_wstrb;
          state_d      = req0_write ? ST_WADDR_DATA : ST_RADDR;
        end
      end
      ST_WADDR_DATA: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        if (m_axi.m_axi_bvalid) begin
          cap_valid = 1'b1;
          cap_resp  = m_axi.m_axi_bresp;
          state_d   = ST_IDLE;
        end
      end
      ST_RADDR: begin
        if (m_axi.m_axi_arready) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (m_axi.m_axi_rvalid) begin
          cap_valid      = 1'b1;
          cap_resp       = m_axi.m_axi_rresp;
          rdata_d[id_q]  = m_axi.m_axi_rdata;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cap_valid) begin
      done_d[id_q] = 1'b1;
      resp_d[id_q] = cap_resp;
      if ((cap_resp != RESP_OKAY) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      done_q       <= 2'b00;
      rdata_q[0]   <= '0;
      rdata_q[1]   <= '0;
      resp_q[0]    <= 2'b00;
      resp_q[1]    <= 2'b00;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign req0_rdata = rdata_q[0];
  assign req1_rdata = rdata_q[1];
  assign req0_resp  = resp_q[0];
  assign req1_resp  = resp_q[1];
  assign busy       = (state_q != ST_IDLE);
  assign err_cnt    = err_cnt_q;

endmodule
